// File: rtl/clock_pkg.sv
// Shared constants for the clock display path.
//   - active-low seven-segment patterns {g,f,e,d,c,b,a}
//   - blink_sel field encodings
//   - digit positions on the 6-digit display (0 = rightmost)
package clock_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  typedef enum logic [1:0] {
    BLINK_NONE = 2'b00,
    BLINK_HOUR = 2'b01,
    BLINK_MIN  = 2'b10,
    BLINK_SEC  = 2'b11
  } blink_sel_e;

  localparam logic [2:0] DIG_SEC_L  = 3'd0;
  localparam logic [2:0] DIG_SEC_H  = 3'd1;
  localparam logic [2:0] DIG_MIN_L  = 3'd2;
  localparam logic [2:0] DIG_MIN_H  = 3'd3;
  localparam logic [2:0] DIG_HOUR_L = 3'd4;
  localparam logic [2:0] DIG_HOUR_H = 3'd5;
  localparam int         NUM_DIGITS = 6;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder.
//   bcd_i : 4-bit digit; values above 9 render as a dash
//   seg_o : {g,f,e,d,c,b,a}, active low
module bcd_to_seg
  import clock_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan6.sv
// 6-digit common-anode display scanner for the digital clock.
//   clk, rst          : clock, async active-high reset
//   hour_h..sec_l     : BCD time digits, captured once per frame
//   blink_sel         : field to blink (none/hours/minutes/seconds)
//   an                : digit enables, active low, an[0] = sec_l
//   seg               : segments {g,f,e,d,c,b,a}, active low
//   dp                : decimal point, active low (separators at digits 4, 2)
module seg_scan6
  import clock_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hour_h,
  input  logic [3:0] hour_l,
  input  logic [3:0] min_h,
  input  logic [3:0] min_l,
  input  logic [3:0] sec_h,
  input  logic [3:0] sec_l,
  input  logic [1:0] blink_sel,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]      presc_q, presc_d;
  logic [2:0]         idx_q, idx_d;
  logic [FW-1:0]      frame_q, frame_d;
  logic               blink_q, blink_d;
  logic [5:0][3:0]    shadow_q, shadow_d;
  logic [5:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;

  logic scan_tick, frame_tick, in_pair, blank;

  assign scan_tick  = (presc_q == PRESC_MAX);
  assign frame_tick = scan_tick && (idx_q == DIG_HOUR_H);

  bcd_to_seg u_dec (
    .bcd_i (shadow_q[idx_q]),
    .seg_o (seg_d)
  );

  always_comb begin
    in_pair = 1'b0;
    case (blink_sel_e'(blink_sel))
      BLINK_HOUR: in_pair = (idx_q == DIG_HOUR_H) || (idx_q == DIG_HOUR_L);
      BLINK_MIN:  in_pair = (idx_q == DIG_MIN_H)  || (idx_q == DIG_MIN_L);
      BLINK_SEC:  in_pair = (idx_q == DIG_SEC_H)  || (idx_q == DIG_SEC_L);
      default:    in_pair = 1'b0;
    endcase
  end

  assign blank = blink_q && in_pair;

  always_comb begin
    presc_d  = scan_tick ? '0 : presc_q + 1'b1;
    idx_d    = idx_q;
    frame_d  = frame_q;
    blink_d  = blink_q;
    shadow_d = shadow_q;
    if (scan_tick) idx_d = (idx_q == DIG_HOUR_H) ? 3'd0 : idx_q + 3'd1;
    // Whole-frame capture keeps a mid-frame input change from tearing the display.
    if (frame_tick) begin
      shadow_d = {hour_h, hour_l, min_h, min_l, sec_h, sec_l};
      if (frame_q == FRAME_MAX) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
    an_d = blank ? 6'b111111 : ~(6'b000001 << idx_q);
    dp_d = !(((idx_q == DIG_HOUR_L) || (idx_q == DIG_MIN_L)) && !blank);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      idx_q    <= '0;
      frame_q  <= '0;
      blink_q  <= 1'b0;
      shadow_q <= '0;
      an_q     <= 6'b111111;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      blink_q  <= blink_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan6.sv
module tb_seg_scan6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] hour_h = 4'd2, hour_l = 4'd3, min_h = 4'd5, min_l = 4'd9;
  logic [3:0] sec_h = 4'd5, sec_l = 4'd8;
  logic [1:0] blink_sel = 2'b00;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;  // rising edges since last reset release

  seg_scan6 #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst),
    .hour_h(hour_h), .hour_l(hour_l), .min_h(min_h), .min_l(min_l),
    .sec_h(sec_h), .sec_l(sec_l), .blink_sel(blink_sel),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  // Advance to cycle n after release (sampled 1 time unit past the edge).
  task automatic step_to(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // First cycle whose registered outputs show digit i of frame f.
  function automatic int at(input int f, input int i);
    return f * 24 + i * 4 + 1;
  endfunction

  function automatic logic [5:0] an_of(input int i);
    logic [5:0] one;
    one = 6'b000001;
    return ~(one << i);
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (an !== 6'b111111 || seg !== 7'h7F || dp !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: an=%b seg=%h dp=%b want an=111111 seg=7f dp=1", an, seg, dp);
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_first_frame;
    logic [5:0] exp_an [0:5];
    exp_an[0] = 6'b111110; exp_an[1] = 6'b111101; exp_an[2] = 6'b111011;
    exp_an[3] = 6'b110111; exp_an[4] = 6'b101111; exp_an[5] = 6'b011111;
    step_to(1);
    checks++;
    if (an !== 6'b111110 || seg !== 7'h40) begin
      errors++;
      $display("FAIL first_output: an=%b seg=%h want an=111110 seg=40", an, seg);
    end
    step_to(4);
    checks++;
    if (an !== 6'b111110) begin
      errors++;
      $display("FAIL dwell_end: an=%b want 111110", an);
    end
    for (int i = 1; i < 6; i++) begin
      step_to(at(0, i));
      checks++;
      if (an !== exp_an[i] || seg !== 7'h40 || dp !== ((i == 2 || i == 4) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL frame1_digit%0d: an=%b seg=%h dp=%b want an=%b seg=40", i, an, seg, dp, exp_an[i]);
      end
    end
  endtask

  task automatic test_second_frame;
    logic [6:0] exp_seg [0:2];
    exp_seg[0] = 7'h00; exp_seg[1] = 7'h12; exp_seg[2] = 7'h10;
    for (int i = 0; i < 3; i++) begin
      step_to(at(1, i));
      checks++;
      if (an !== an_of(i) || seg !== exp_seg[i]) begin
        errors++;
        $display("FAIL frame2_digit%0d: an=%b seg=%h want an=%b seg=%h", i, an, seg, an_of(i), exp_seg[i]);
      end
    end
  endtask

  // Sits at digit 2 of frame 2 on entry.
  task automatic test_tear_free;
    logic [6:0] exp_seg [3:5];
    exp_seg[3] = 7'h12; exp_seg[4] = 7'h30; exp_seg[5] = 7'h24;
    hour_l = 4'd4;
    for (int i = 3; i < 6; i++) begin
      step_to(at(1, i));
      checks++;
      if (an !== an_of(i) || seg !== exp_seg[i]) begin
        errors++;
        $display("FAIL tear_digit%0d: an=%b seg=%h want an=%b seg=%h", i, an, seg, an_of(i), exp_seg[i]);
      end
    end
    // Frame 3 is in blink phase 1 but blink_sel is 00: nothing blanks.
    step_to(at(2, 4));
    checks++;
    if (an !== 6'b101111 || seg !== 7'h19 || dp !== 1'b0) begin
      errors++;
      $display("FAIL tear_next_frame: an=%b seg=%h dp=%b want an=101111 seg=19 dp=0", an, seg, dp);
    end
    step_to(at(2, 5));
    checks++;
    if (an !== 6'b011111 || seg !== 7'h24) begin
      errors++;
      $display("FAIL none_no_blank: an=%b seg=%h want an=011111 seg=24", an, seg);
    end
  endtask

  task automatic test_blink_hours;
    step_to(at(4, 0));
    blink_sel = 2'b01;
    step_to(at(4, 5));
    checks++;
    if (an !== 6'b011111 || seg !== 7'h24) begin
      errors++;
      $display("FAIL blink_phase0: an=%b seg=%h want an=011111 seg=24", an, seg);
    end
    step_to(at(6, 0));
    checks++;
    if (an !== 6'b111110 || seg !== 7'h00) begin
      errors++;
      $display("FAIL blink_other_digit: an=%b seg=%h want an=111110 seg=00", an, seg);
    end
    step_to(at(6, 2));
    checks++;
    if (an !== 6'b111011 || dp !== 1'b0) begin
      errors++;
      $display("FAIL blink_min_sep: an=%b dp=%b want an=111011 dp=0", an, dp);
    end
    step_to(at(6, 4));
    checks++;
    if (an !== 6'b111111 || dp !== 1'b1) begin
      errors++;
      $display("FAIL blink_hour_l: an=%b dp=%b want an=111111 dp=1", an, dp);
    end
    step_to(at(7, 5) + 3);
    checks++;
    if (an !== 6'b111111) begin
      errors++;
      $display("FAIL blink_hour_h_end: an=%b want 111111", an);
    end
    step_to(at(8, 4));
    checks++;
    if (an !== 6'b101111 || seg !== 7'h19 || dp !== 1'b0) begin
      errors++;
      $display("FAIL blink_restored: an=%b seg=%h dp=%b want an=101111 seg=19 dp=0", an, seg, dp);
    end
  endtask

  task automatic test_blink_seconds;
    blink_sel = 2'b11;
    step_to(at(10, 1));
    checks++;
    if (an !== 6'b111111 || dp !== 1'b1) begin
      errors++;
      $display("FAIL blink_sec_h: an=%b dp=%b want an=111111 dp=1", an, dp);
    end
    step_to(at(10, 4));
    checks++;
    if (an !== 6'b101111 || dp !== 1'b0) begin
      errors++;
      $display("FAIL blink_sec_hour_shown: an=%b dp=%b want an=101111 dp=0", an, dp);
    end
    blink_sel = 2'b00;
  endtask

  task automatic test_invalid_bcd;
    step_to(at(11, 2));
    sec_l = 4'hA;
    step_to(at(12, 0));
    checks++;
    if (an !== 6'b111110 || seg !== 7'h3F) begin
      errors++;
      $display("FAIL invalid_bcd: an=%b seg=%h want an=111110 seg=3f", an, seg);
    end
  endtask

  task automatic test_async_reset;
    step_to(at(12, 3));
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (an !== 6'b111111 || seg !== 7'h7F || dp !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: an=%b seg=%h dp=%b want an=111111 seg=7f dp=1", an, seg, dp);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
    step_to(1);
    checks++;
    if (an !== 6'b111110 || seg !== 7'h40) begin
      errors++;
      $display("FAIL restart_digit0: an=%b seg=%h want an=111110 seg=40", an, seg);
    end
    step_to(at(0, 1));
    checks++;
    if (an !== 6'b111101 || seg !== 7'h40) begin
      errors++;
      $display("FAIL restart_digit1: an=%b seg=%h want an=111101 seg=40", an, seg);
    end
  endtask

  initial begin
    test_reset;
    test_first_frame;
    test_second_frame;
    test_tear_free;
    test_blink_hours;
    test_blink_seconds;
    test_invalid_bcd;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
